dual_issue_fetch_sequencer: RTL and testbench
=============================================

# dual_issue_fetch_sequencer

Fetch-side sequencer for the dual-issue pipeline. It owns the PC, the two IF/ID lane registers and the `first` lane-ordering bit. It consumes the stall/nop/clear masks from the hazard detection unit and decides what each lane loads at every edge. On a split issue it refills only the lane that issued, then reverses lane order so program order is preserved. It also counts stall and split cycles for performance debug.

## Interface
- `ADDR_W`, 16: PC / instruction-address width.
- `INST_W`, 32: instruction word width; opcode is bits [INST_W-1:INST_W-6].
- `CNT_W`, 16: width of the performance counters.

- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `stall0`, `stall1` in `NUM_PIPE_MASKS`: hazard stall masks; only the `PIPE_REG_PC` and `PIPE_REG_IF_ID` bits are used.
- `clear0`, `clear1` in 1: the lane's IF/ID entry has issued and must be refilled.
- `branch_taken` in 1: flush request from EX.
- `branch_target` in ADDR_W: redirect PC.
- `imem_addr0`, `imem_addr1` out ADDR_W: fetch addresses, combinational from PC state.
- `imem_data0`, `imem_data1` in INST_W: instruction words, valid in the same cycle as the addresses.
- `if_id_instr0`, `if_id_instr1` out INST_W: registered lane instructions.
- `if_id_pc0`, `if_id_pc1` out ADDR_W: registered lane PCs.
- `if_id_valid0`, `if_id_valid1` out 1: lane holds a live instruction.
- `first` out 1: registered. 1 means lane 1 is older, 0 means lane 0 is older. Drives the hazard unit.
- `stall_cnt`, `split_cnt` out CNT_W: saturating event counters.

## Operation
- Internal `pc` is the next sequential fetch address.
- Fetch addressing:
  - Lane that will receive the older instruction: `pc`.
  - Other lane: `pc+1`.
  - On a split (see below), `imem_addr` of the refilled lane is `pc`.
- Decode per edge, highest priority first:
  1. **reset:**
     - `pc`=0, `first`=0.
     - Both `if_id_instr` = `OP_CODE_NOP` with low bits zero.
     - `if_id_pc`=0, `if_id_valid`=0.
     - Counters = 0.
  2. **FLUSH** (`branch_taken`):
     - Both lanes load NOP, valid=0.
     - `pc`=`branch_target`, `first`=0.
     - Overrides any stall or clear in the same cycle.
  3. **HOLD** (PC bit set in `stall0|stall1`, and `clear0`=`clear1`=0):
     - All lane registers, `pc` and `first` unchanged.
     - `stall_cnt`++.
  4. **SPLIT** (exactly one of `clear0`/`clear1` set, PC bit set):
     - The cleared lane k loads `imem_data_k` from address `pc`, with `if_id_pc_k`=`pc` and valid=1.
     - The other lane holds.
     - `pc`=`pc+1`.
     - `first` toggles: the held lane becomes older.
     - `split_cnt`++.
  5. **ADVANCE** (otherwise, including `clear0`=`clear1`=1):
     - Older lane (per current `first`) loads from `pc`; younger lane loads from `pc+1`; both valid=1.
     - `pc`=`pc+2`.
     - `first` unchanged.
- Lane-ordering invariant: valid lanes always satisfy `if_id_pc(younger)` = `if_id_pc(older)+1` mod 2^ADDR_W, except immediately after FLUSH.
- Arithmetic:
  - PC adds wrap modulo 2^ADDR_W; `pc`=all-ones fetches all-ones and 0.
  - Counters saturate at 2^CNT_W-1 and do not wrap.
- `stall0`/`stall1` IF_ID bits are consistent with PC bits by contract. The block acts on the PC bit only; a lane with a set IF_ID bit and no clear is never written.

## Timing
- Zero-cycle decision: hazard inputs are sampled at the same edge they are produced for; all lane outputs and `first` are registered.
- After FLUSH, lanes are invalid for exactly one cycle. Target instructions appear at cycle +2 relative to the `branch_taken` edge.
- A SPLIT takes one cycle; `first` reflects the new order on the following cycle.
- Reset asserted mid-HOLD or mid-SPLIT wins at that edge. No partial update survives.
- Counters update on the same edge as the state transition.

## Test plan
- **Reset then 3 cycles, no hazards:** imem returns `{addr}`. Lanes show pc pairs (0,1), (2,3), (4,5), `first`=0, valid=1 from cycle 1.
- **Load-use hold:** at pair (4,5) assert PC|IF_ID|ID_EX on both stalls for 2 cycles → lanes stay (4,5), `pc`=6, `stall_cnt`=2, then resume at (6,7).
- **Split with `first`=0, lane 0 issued:** at (4,5) assert `clear0` with PC bit → lane 0 = 6, lane 1 holds 5, `first`=1, `pc`=7, `split_cnt`=1. The next advance gives lane 1=7, lane 0=8.
- **Flush vs. split:** `branch_taken` with target 0x0100 in the same cycle as `clear1` → both valid=0, `first`=0. The next cycle shows (0x0100, 0x0101).
- **Wrap:** branch to 0xFFFF → lanes (0xFFFF, 0x0000), then (0x0001, 0x0002).
- **Saturation and reset:** force `CNT_W`=4 and hold 20 cycles → `stall_cnt`=15. Assert `reset` mid-hold → all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/dual_issue_fetch_sequencer.sv
// Dual-issue fetch sequencer: owns the PC, both IF/ID lane registers and the lane-order bit,
// and decides per edge between flush, hold, single-lane split refill and dual advance.
module dual_issue_fetch_sequencer #(
  parameter int         ADDR_W         = 16,
  parameter int         INST_W         = 32,
  parameter int         CNT_W          = 16,
  parameter int         NUM_PIPE_MASKS = 5,
  parameter int         PIPE_REG_PC    = 0,
  parameter int         PIPE_REG_IF_ID = 1,
  parameter logic [5:0] OP_CODE_NOP    = 6'h13
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [NUM_PIPE_MASKS-1:0] i_stall0,
  input  logic [NUM_PIPE_MASKS-1:0] i_stall1,
  input  logic                      i_clear0,
  input  logic                      i_clear1,
  input  logic                      i_branch_taken,
  input  logic [ADDR_W-1:0]         i_branch_target,
  output logic [ADDR_W-1:0]         o_imem_addr0,
  output logic [ADDR_W-1:0]         o_imem_addr1,
  input  logic [INST_W-1:0]         i_imem_data0,
  input  logic [INST_W-1:0]         i_imem_data1,
  output logic [INST_W-1:0]         o_if_id_instr0,
  output logic [INST_W-1:0]         o_if_id_instr1,
  output logic [ADDR_W-1:0]         o_if_id_pc0,
  output logic [ADDR_W-1:0]         o_if_id_pc1,
  output logic                      o_if_id_valid0,
  output logic                      o_if_id_valid1,
  output logic                      o_first,
  output logic [CNT_W-1:0]          o_stall_cnt,
  output logic [CNT_W-1:0]          o_split_cnt
);

  localparam logic [INST_W-1:0] NOP_WORD = {OP_CODE_NOP, {(INST_W-6){1'b0}}};
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    MODE_ADVANCE = 2'd0,
    MODE_FLUSH   = 2'd1,
    MODE_HOLD    = 2'd2,
    MODE_SPLIT   = 2'd3
  } mode_t;

  logic [ADDR_W-1:0] r_pc;
  logic              r_first;
  logic [INST_W-1:0] r_instr0, r_instr1;
  logic [ADDR_W-1:0] r_lpc0, r_lpc1;
  logic              r_valid0, r_valid1;
  logic [CNT_W-1:0]  r_stall_cnt, r_split_cnt;

  logic [ADDR_W-1:0] w_pc_nxt;
  logic              w_first_nxt;
  logic [INST_W-1:0] w_instr0_nxt, w_instr1_nxt;
  logic [ADDR_W-1:0] w_lpc0_nxt, w_lpc1_nxt;
  logic              w_valid0_nxt, w_valid1_nxt;
  logic [CNT_W-1:0]  w_stall_cnt_nxt, w_split_cnt_nxt;

  mode_t             w_mode;
  logic              w_pc_stall;
  logic [ADDR_W-1:0] w_pc_p1;
  logic [ADDR_W-1:0] w_addr0, w_addr1;
  logic              w_unused_stall_bits;

  // The IF_ID bits mirror the PC bits by contract, so only the PC bit steers the sequencer.
  assign w_pc_stall          = i_stall0[PIPE_REG_PC] | i_stall1[PIPE_REG_PC];
  assign w_unused_stall_bits = ^{i_stall0, i_stall1, i_stall0[PIPE_REG_IF_ID]};
  assign w_pc_p1             = r_pc + ADDR_W'(1);

  // Per-edge action decode, highest priority first.
  always_comb begin
    w_mode = MODE_ADVANCE;
    if (i_branch_taken) begin
      w_mode = MODE_FLUSH;
    end else if (w_pc_stall && !i_clear0 && !i_clear1) begin
      w_mode = MODE_HOLD;
    end else if (w_pc_stall && (i_clear0 != i_clear1)) begin
      w_mode = MODE_SPLIT;
    end else begin
      w_mode = MODE_ADVANCE;
    end
  end

  // Fetch addresses: the older-bound lane reads pc; on a split the refilled lane reads pc.
  always_comb begin
    w_addr0 = r_pc;
    w_addr1 = w_pc_p1;
    if (w_mode == MODE_SPLIT) begin
      w_addr0 = i_clear0 ? r_pc : w_pc_p1;
      w_addr1 = i_clear1 ? r_pc : w_pc_p1;
    end else if (r_first) begin
      w_addr0 = w_pc_p1;
      w_addr1 = r_pc;
    end else begin
      w_addr0 = r_pc;
      w_addr1 = w_pc_p1;
    end
  end

  assign o_imem_addr0 = w_addr0;
  assign o_imem_addr1 = w_addr1;

  // Next-state computation for PC, lane registers, order bit and counters.
  always_comb begin
    w_pc_nxt        = r_pc;
    w_first_nxt     = r_first;
    w_instr0_nxt    = r_instr0;
    w_instr1_nxt    = r_instr1;
    w_lpc0_nxt      = r_lpc0;
    w_lpc1_nxt      = r_lpc1;
    w_valid0_nxt    = r_valid0;
    w_valid1_nxt    = r_valid1;
    w_stall_cnt_nxt = r_stall_cnt;
    w_split_cnt_nxt = r_split_cnt;
    case (w_mode)
      MODE_FLUSH: begin
        w_instr0_nxt = NOP_WORD;
        w_instr1_nxt = NOP_WORD;
        w_lpc0_nxt   = {ADDR_W{1'b0}};
        w_lpc1_nxt   = {ADDR_W{1'b0}};
        w_valid0_nxt = 1'b0;
        w_valid1_nxt = 1'b0;
        w_pc_nxt     = i_branch_target;
        w_first_nxt  = 1'b0;
      end
      MODE_HOLD: begin
        if (r_stall_cnt != CNT_MAX) begin
          w_stall_cnt_nxt = r_stall_cnt + CNT_W'(1);
        end else begin
          w_stall_cnt_nxt = r_stall_cnt;
        end
      end
      MODE_SPLIT: begin
        if (i_clear0) begin
          w_instr0_nxt = i_imem_data0;
          w_lpc0_nxt   = r_pc;
          w_valid0_nxt = 1'b1;
        end else begin
          w_instr1_nxt = i_imem_data1;
          w_lpc1_nxt   = r_pc;
          w_valid1_nxt = 1'b1;
        end
        w_pc_nxt    = w_pc_p1;
        w_first_nxt = ~r_first;
        if (r_split_cnt != CNT_MAX) begin
          w_split_cnt_nxt = r_split_cnt + CNT_W'(1);
        end else begin
          w_split_cnt_nxt = r_split_cnt;
        end
      end
      MODE_ADVANCE: begin
        w_instr0_nxt = i_imem_data0;
        w_instr1_nxt = i_imem_data1;
        w_lpc0_nxt   = w_addr0;
        w_lpc1_nxt   = w_addr1;
        w_valid0_nxt = 1'b1;
        w_valid1_nxt = 1'b1;
        w_pc_nxt     = r_pc + ADDR_W'(2);
      end
      default: begin
        w_pc_nxt = r_pc;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pc        <= {ADDR_W{1'b0}};
      r_first     <= 1'b0;
      r_instr0    <= NOP_WORD;
      r_instr1    <= NOP_WORD;
      r_lpc0      <= {ADDR_W{1'b0}};
      r_lpc1      <= {ADDR_W{1'b0}};
      r_valid0    <= 1'b0;
      r_valid1    <= 1'b0;
      r_stall_cnt <= {CNT_W{1'b0}};
      r_split_cnt <= {CNT_W{1'b0}};
    end else begin
      r_pc        <= w_pc_nxt;
      r_first     <= w_first_nxt;
      r_instr0    <= w_instr0_nxt;
      r_instr1    <= w_instr1_nxt;
      r_lpc0      <= w_lpc0_nxt;
      r_lpc1      <= w_lpc1_nxt;
      r_valid0    <= w_valid0_nxt;
      r_valid1    <= w_valid1_nxt;
      r_stall_cnt <= w_stall_cnt_nxt;
      r_split_cnt <= w_split_cnt_nxt;
    end
  end

  assign o_if_id_instr0 = r_instr0;
  assign o_if_id_instr1 = r_instr1;
  assign o_if_id_pc0    = r_lpc0;
  assign o_if_id_pc1    = r_lpc1;
  assign o_if_id_valid0 = r_valid0;
  assign o_if_id_valid1 = r_valid1;
  assign o_first        = r_first;
  assign o_stall_cnt    = r_stall_cnt;
  assign o_split_cnt    = r_split_cnt;

endmodule

// File: tb/tb_dual_issue_fetch_sequencer.sv
// Bench for dual_issue_fetch_sequencer: directed plan steps then random traffic,
// checked against a lane-order model (older lane index + sequential fetch pointer).
module tb_dual_issue_fetch_sequencer;
  localparam int ADDR_W = 16;
  localparam int INST_W = 32;
  localparam int CNT_W  = 4;
  localparam int NPM    = 5;
  localparam int CMAX   = 15;
  localparam logic [5:0]  NOP_OP = 6'h13;
  localparam logic [31:0] NOP_W  = {NOP_OP, 26'd0};

  logic              clk = 1'b0;
  logic              i_reset, i_clear0, i_clear1, i_branch_taken;
  logic [NPM-1:0]    i_stall0, i_stall1;
  logic [ADDR_W-1:0] i_branch_target;
  logic [ADDR_W-1:0] o_imem_addr0, o_imem_addr1, o_if_id_pc0, o_if_id_pc1;
  logic [INST_W-1:0] i_imem_data0, i_imem_data1, o_if_id_instr0, o_if_id_instr1;
  logic              o_if_id_valid0, o_if_id_valid1, o_first;
  logic [CNT_W-1:0]  o_stall_cnt, o_split_cnt;

  dual_issue_fetch_sequencer #(
    .ADDR_W(ADDR_W), .INST_W(INST_W), .CNT_W(CNT_W), .NUM_PIPE_MASKS(NPM),
    .PIPE_REG_PC(0), .PIPE_REG_IF_ID(1), .OP_CODE_NOP(NOP_OP)
  ) dut (
    .i_clk(clk), .i_reset(i_reset), .i_stall0(i_stall0), .i_stall1(i_stall1),
    .i_clear0(i_clear0), .i_clear1(i_clear1), .i_branch_taken(i_branch_taken),
    .i_branch_target(i_branch_target), .o_imem_addr0(o_imem_addr0), .o_imem_addr1(o_imem_addr1),
    .i_imem_data0(i_imem_data0), .i_imem_data1(i_imem_data1),
    .o_if_id_instr0(o_if_id_instr0), .o_if_id_instr1(o_if_id_instr1),
    .o_if_id_pc0(o_if_id_pc0), .o_if_id_pc1(o_if_id_pc1),
    .o_if_id_valid0(o_if_id_valid0), .o_if_id_valid1(o_if_id_valid1),
    .o_first(o_first), .o_stall_cnt(o_stall_cnt), .o_split_cnt(o_split_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {~a, a};
  endfunction

  always_comb begin
    i_imem_data0 = mem_word(o_imem_addr0);
    i_imem_data1 = mem_word(o_imem_addr1);
  end

  // Reference model: program-order view of the two lanes.
  int          m_pc, m_older, m_stall, m_split;
  int          m_lpc [2];
  bit          m_val [2];
  logic [31:0] m_ins [2];
  int          n_checks, n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_older = 0; m_stall = 0; m_split = 0;
    for (int i = 0; i < 2; i++) begin
      m_lpc[i] = 0; m_val[i] = 1'b0; m_ins[i] = NOP_W;
    end
  endtask

  task automatic model_load(input int lane, input int a);
    m_lpc[lane] = a & 'hFFFF;
    m_ins[lane] = mem_word(16'(a & 'hFFFF));
    m_val[lane] = 1'b1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid0"}, 32'(o_if_id_valid0), 32'(m_val[0]));
    chk({tag, ".valid1"}, 32'(o_if_id_valid1), 32'(m_val[1]));
    chk({tag, ".instr0"}, o_if_id_instr0, m_ins[0]);
    chk({tag, ".instr1"}, o_if_id_instr1, m_ins[1]);
    if (m_val[0]) chk({tag, ".pc0"}, 32'(o_if_id_pc0), 32'(m_lpc[0]));
    if (m_val[1]) chk({tag, ".pc1"}, 32'(o_if_id_pc1), 32'(m_lpc[1]));
    chk({tag, ".first"}, 32'(o_first), 32'(m_older));
    chk({tag, ".stall_cnt"}, 32'(o_stall_cnt), 32'(m_stall));
    chk({tag, ".split_cnt"}, 32'(o_split_cnt), 32'(m_split));
  endtask

  // One clock: drive at negedge, check fetch addresses, then check registered state after the edge.
  task automatic cyc(input string tag, input bit rst, input bit br, input int tgt,
                     input bit spc, input bit c0, input bit c1);
    logic [NPM-1:0] s0, s1;
    int sel, k, ea [2];
    bit is_split;
    @(negedge clk);
    s0 = NPM'($urandom) & 5'b11100;
    s1 = NPM'($urandom) & 5'b11100;
    if (spc) begin
      sel = $urandom_range(0, 2);
      if (sel != 1) s0 = s0 | 5'b00011;
      if (sel != 0) s1 = s1 | 5'b00011;
    end
    i_reset = rst; i_branch_taken = br; i_branch_target = tgt[15:0];
    i_stall0 = s0; i_stall1 = s1; i_clear0 = c0; i_clear1 = c1;
    is_split = !br && spc && (c0 != c1);
    k = c0 ? 0 : 1;
    if (is_split) begin
      ea[k] = m_pc; ea[1-k] = (m_pc + 1) & 'hFFFF;
    end else begin
      ea[m_older] = m_pc; ea[1-m_older] = (m_pc + 1) & 'hFFFF;
    end
    #1;
    if (!rst) begin
      chk({tag, ".addr0"}, 32'(o_imem_addr0), 32'(ea[0]));
      chk({tag, ".addr1"}, 32'(o_imem_addr1), 32'(ea[1]));
    end
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (br) begin
      for (int i = 0; i < 2; i++) begin m_val[i] = 1'b0; m_ins[i] = NOP_W; end
      m_pc = tgt & 'hFFFF; m_older = 0;
    end else if (spc && !c0 && !c1) begin
      if (m_stall < CMAX) m_stall++;
    end else if (is_split) begin
      model_load(k, m_pc);
      m_pc = (m_pc + 1) & 'hFFFF;
      m_older = 1 - k;
      if (m_split < CMAX) m_split++;
    end else begin
      model_load(m_older, m_pc);
      model_load(1 - m_older, m_pc + 1);
      m_pc = (m_pc + 2) & 'hFFFF;
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    int r, cs;
    bit rr, rb, rs, c0, c1;
    n_checks = 0; n_fail = 0;
    i_reset = 1'b1; i_branch_taken = 1'b0; i_branch_target = '0;
    i_stall0 = '0; i_stall1 = '0; i_clear0 = 1'b0; i_clear1 = 1'b0;
    model_reset();

    cyc("reset", 1, 0, 0, 0, 0, 0);
    cyc("reset", 1, 0, 0, 0, 0, 0);
    chk("reset.nop", o_if_id_instr0, NOP_W);
    repeat (3) cyc("advance", 0, 0, 0, 0, 0, 0);
    chk("advance.lane0", 32'(o_if_id_pc0), 32'd4);
    chk("advance.lane1", 32'(o_if_id_pc1), 32'd5);

    repeat (2) cyc("hold", 0, 0, 0, 1, 0, 0);
    chk("hold.stall_cnt", 32'(o_stall_cnt), 32'd2);
    chk("hold.lane0", 32'(o_if_id_pc0), 32'd4);

    cyc("split", 0, 0, 0, 1, 1, 0);
    chk("split.lane0", 32'(o_if_id_pc0), 32'd6);
    chk("split.lane1", 32'(o_if_id_pc1), 32'd5);
    chk("split.first", 32'(o_first), 32'd1);
    cyc("post_split", 0, 0, 0, 0, 0, 0);
    chk("post_split.lane1", 32'(o_if_id_pc1), 32'd7);
    chk("post_split.lane0", 32'(o_if_id_pc0), 32'd8);

    cyc("flush_split", 0, 1, 'h0100, 1, 0, 1);
    cyc("flush_next", 0, 0, 0, 0, 0, 0);
    chk("flush_next.lane0", 32'(o_if_id_pc0), 32'h0100);
    chk("flush_next.lane1", 32'(o_if_id_pc1), 32'h0101);
    cyc("both_clear", 0, 0, 0, 1, 1, 1);

    cyc("wrap_br", 0, 1, 'hFFFF, 0, 0, 0);
    cyc("wrap1", 0, 0, 0, 0, 0, 0);
    chk("wrap1.lane0", 32'(o_if_id_pc0), 32'hFFFF);
    chk("wrap1.lane1", 32'(o_if_id_pc1), 32'h0000);
    cyc("wrap2", 0, 0, 0, 0, 0, 0);
    chk("wrap2.lane0", 32'(o_if_id_pc0), 32'h0001);

    repeat (20) cyc("sat_hold", 0, 0, 0, 1, 0, 0);
    chk("sat.stall_cnt", 32'(o_stall_cnt), 32'd15);
    cyc("reset_mid_hold", 1, 0, 0, 1, 0, 0);
    chk("reset_mid_hold.valid0", 32'(o_if_id_valid0), 32'd0);
    chk("reset_mid_hold.stall_cnt", 32'(o_stall_cnt), 32'd0);

    // Random traffic: splits only ever retire the older lane, as an in-order issue stage would.
    for (int n = 0; n < 400; n++) begin
      r  = $urandom_range(0, 99);
      rr = (r < 2);
      rb = (r >= 2 && r < 8);
      rs = ($urandom_range(0, 2) == 0);
      cs = $urandom_range(0, 3);
      c0 = 1'b0; c1 = 1'b0;
      if (cs == 1 || (cs == 3 && rs)) begin
        if (m_older == 0) c0 = 1'b1; else c1 = 1'b1;
      end else if (cs == 2) begin
        c0 = 1'b1; c1 = 1'b1;
      end else if (cs == 3) begin
        if (m_older == 0) c1 = 1'b1; else c0 = 1'b1;
      end else begin
        c0 = 1'b0;
      end
      cyc("random", rr, rb, int'($urandom_range(0, 65535)), rs, c0, c1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
